// File: rtl/mem_responder.sv
// Word-addressed memory slave with a four-state FSM; one-cycle mem_ready strobe WAIT_CYCLES+1 cycles after the request is sampled.
// Request is latched once, then held off in HOLD until both request levels drop, so a held request is serviced once.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        mem_ready,
  output logic        addr_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [31:0]           lat_wdata;
  logic                  lat_wr;
  logic                  lat_err;

  logic                  req;
  logic                  req_err;
  logic                  enter_resp;
  logic                  mem_we;
  logic                  op_wr;
  logic                  op_err;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [31:0]           op_wdata;

  logic [31:0]           mem [WORDS];

  assign req = mem_read | mem_write;

  // Misaligned, beyond the array, or an ambiguous read+write request.
  assign req_err = (data_addr[1:0] != 2'b00)
                || ((data_addr >> (DEPTH_LOG2 + 2)) != 32'd0)
                || (mem_read && mem_write);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    op_idx     = lat_idx;
    op_wdata   = lat_wdata;
    op_wr      = lat_wr;
    op_err     = lat_err;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the request is serviced straight from the inputs.
            state_nxt  = RESP;
            enter_resp = 1'b1;
            op_idx     = data_addr[DEPTH_LOG2+1:2];
            op_wdata   = wr_data;
            op_wr      = mem_write;
            op_err     = req_err;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt  = RESP;
          cnt_nxt    = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: state_nxt = HOLD;
      HOLD: begin
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rst gating keeps a zero-wait request from committing while reset is held.
  assign mem_we = enter_resp && op_wr && !op_err && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rd_data   <= 32'd0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        lat_idx   <= data_addr[DEPTH_LOG2+1:2];
        lat_wdata <= wr_data;
        lat_wr    <= mem_write;
        lat_err   <= req_err;
      end
      if (enter_resp) begin
        if (op_err) begin
          rd_data <= 32'd0;
        end else if (!op_wr) begin
          rd_data <= mem[op_idx];
        end
      end
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem[op_idx] <= op_wdata;
  end

  assign mem_ready = (state == RESP);
  assign addr_err  = (state == RESP) && lat_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut_a uses two wait states over 256 words, dut_b uses zero wait states over 16 words.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_addr, a_wdat, b_addr, b_wdat;
  logic [31:0] a_rdat, b_rdat;
  logic        a_ready, a_err, b_ready, b_err;

  int n_cmp = 0;
  int n_err = 0;

  int          lat;
  logic        err;
  logic [31:0] rdat;
  int          p1, p2, pr;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr),
    .data_addr(a_addr), .wr_data(a_wdat), .rd_data(a_rdat),
    .mem_ready(a_ready), .addr_err(a_err)
  );

  mem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr),
    .data_addr(b_addr), .wr_data(b_wdat), .rd_data(b_rdat),
    .mem_ready(b_ready), .addr_err(b_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdat);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdat = wdat;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdat = wdat;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  // Issue one request, measure edges until mem_ready, then release and let HOLD drain.
  task automatic do_req(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdat, input bit glitch,
                        output int lat_o, output logic err_o, output logic [31:0] rdat_o);
    drive(sel, rd, wr, addr, wdat);
    lat_o  = 0;
    err_o  = 1'bx;
    rdat_o = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (glitch && k == 1) drive(sel, rd, wr, addr ^ 32'h4, ~wdat);
      if (rdy(sel)) begin
        lat_o  = k;
        err_o  = sel ? b_err : a_err;
        rdat_o = sel ? b_rdat : a_rdat;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("ready_single_cycle", {31'd0, rdy(sel)}, 32'd0);
    chk("err_low_without_ready", {31'd0, sel ? b_err : a_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, a_ready}, 32'd0);
    chk("reset_err", {31'd0, a_err}, 32'd0);
    chk("reset_rdata", a_rdat, 32'd0);
    chk("reset_ready_b", {31'd0, b_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, err, rdat);
    chk("wr10_latency", lat, 32'd3);
    chk("wr10_err", {31'd0, err}, 32'd0);
    chk("wr10_rdata_unchanged", rdat, 32'd0);

    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, lat, err, rdat);
    chk("rd10_latency", lat, 32'd3);
    chk("rd10_err", {31'd0, err}, 32'd0);
    chk("rd10_data", rdat, 32'hDEADBEEF);

    // Inputs change right after sampling; latched values must win.
    do_req(1'b0, 1'b0, 1'b1, 32'h0, 32'hA5A50000, 1'b1, lat, err, rdat);
    chk("wr0_latency", lat, 32'd3);
    do_req(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, lat, err, rdat);
    chk("rd0_data", rdat, 32'hA5A50000);

    do_req(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 1'b0, lat, err, rdat);
    chk("misalign_latency", lat, 32'd3);
    chk("misalign_err", {31'd0, err}, 32'd1);
    chk("misalign_rdata", rdat, 32'd0);
    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, lat, err, rdat);
    chk("after_misalign_rd10", rdat, 32'hDEADBEEF);

    do_req(1'b0, 1'b0, 1'b1, 32'h400, 32'h11111111, 1'b0, lat, err, rdat);
    chk("oor_err", {31'd0, err}, 32'd1);
    do_req(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, lat, err, rdat);
    chk("after_oor_rd0", rdat, 32'hA5A50000);

    do_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h22222222, 1'b0, lat, err, rdat);
    chk("both_err", {31'd0, err}, 32'd1);
    chk("both_rdata", rdat, 32'd0);
    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, lat, err, rdat);
    chk("after_both_rd10", rdat, 32'hDEADBEEF);

    p1 = 0;
    p2 = 0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (a_ready) p1++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      if (a_ready) p1++;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (a_ready) p2++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_first_pulses", p1, 32'd1);
    chk("held_second_pulses", p2, 32'd1);

    do_req(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, lat, err, rdat);
    chk("wr20_latency", lat, 32'd3);
    pr = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rst_in_wait_rdata", a_rdat, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (a_ready) pr++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (a_ready) pr++;
    end
    chk("rst_in_wait_no_ready", pr, 32'd0);
    do_req(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, lat, err, rdat);
    chk("rst_in_wait_rd20", rdat, 32'hCAFEF00D);

    do_req(1'b1, 1'b0, 1'b1, 32'h8, 32'h0BADCAFE, 1'b0, lat, err, rdat);
    chk("w0_wr_latency", lat, 32'd1);
    chk("w0_wr_err", {31'd0, err}, 32'd0);
    do_req(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0, lat, err, rdat);
    chk("w0_rd_latency", lat, 32'd1);
    chk("w0_rd_data", rdat, 32'h0BADCAFE);
    do_req(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, lat, err, rdat);
    chk("w0_oor_err", {31'd0, err}, 32'd1);
    chk("w0_oor_rdata", rdat, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
